// File: rtl/instr_dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: opcodes, instruction field layout,
// FSM state encoding and error bit indices.
package dispatch_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_CONV  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;

  localparam int unsigned INSTR_W  = 64;
  localparam int unsigned OPC_LSB  = 60;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ADDR_LSB = 40;
  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned LEN_LSB  = 24;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned CFG_LSB  = 0;
  localparam int unsigned CFG_W    = 24;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam int unsigned ERR_W      = 2;
  localparam int unsigned ERR_OPC_TO = 0;  // illegal opcode or unit timeout
  localparam int unsigned ERR_BUSY   = 1;  // instruction arrived while busy

  function automatic logic op_is_unit(logic [OPC_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_CONV) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/instr_dispatch_if.sv
// Instruction bus, execution-unit handshake and status signals of the dispatcher.
interface instr_dispatch_if;
  import dispatch_pkg::*;

  logic                instr_en;
  logic [INSTR_W-1:0]  instr;
  logic                err_clr;
  logic                load_done;
  logic                conv_done;
  logic                store_done;
  logic                load_start;
  logic                conv_start;
  logic                store_start;
  logic [ADDR_W-1:0]   param_addr;
  logic [LEN_W-1:0]    param_len;
  logic [CFG_W-1:0]    param_cfg;
  logic                instr_done;
  logic                busy;
  logic [ERR_W-1:0]    err_code;

  modport master (
    output instr_en, instr, err_clr, load_done, conv_done, store_done,
    input  load_start, conv_start, store_start, param_addr, param_len, param_cfg,
           instr_done, busy, err_code
  );

  modport slave (
    input  instr_en, instr, err_clr, load_done, conv_done, store_done,
    output load_start, conv_start, store_start, param_addr, param_len, param_cfg,
           instr_done, busy, err_code
  );

endinterface

// File: rtl/instr_dispatch_timeout_cnt.sv
// WAIT-state cycle counter; expired_o flags the last permitted WAIT cycle.
module dispatch_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Counting this cycle would make the total reach TIMEOUT_CYCLES.
  assign expired_o = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_dispatch.sv
// Decodes accepted instructions, starts the addressed execution unit, waits for its done
// (bounded by a timeout) and returns a one-cycle completion pulse.
module instr_dispatch
  import dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  instr_dispatch_if.slave   bus
);

  state_e             state_q;
  logic [OPC_W-1:0]   opcode_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [CFG_W-1:0]   cfg_q;
  logic               load_start_q;
  logic               conv_start_q;
  logic               store_start_q;
  logic               instr_done_q;
  logic               busy_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_set;
  logic               sel_done;
  logic               cnt_expired;

  dispatch_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == StIssue),
    .en_i      ((state_q == StWait) && !sel_done),
    .expired_o (cnt_expired)
  );

  always_comb begin
    sel_done = 1'b0;
    unique case (opcode_q)
      OP_LOAD:  sel_done = bus.load_done;
      OP_CONV:  sel_done = bus.conv_done;
      OP_STORE: sel_done = bus.store_done;
      default:  sel_done = 1'b0;
    endcase
  end

  always_comb begin
    err_set             = '0;
    err_set[ERR_BUSY]   = bus.instr_en && (state_q != StIdle);
    err_set[ERR_OPC_TO] = ((state_q == StDecode) && (opcode_q != OP_NOP) &&
                           !op_is_unit(opcode_q)) ||
                          ((state_q == StWait) && !sel_done && cnt_expired);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      opcode_q      <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      cfg_q         <= '0;
      load_start_q  <= 1'b0;
      conv_start_q  <= 1'b0;
      store_start_q <= 1'b0;
      instr_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= '0;
    end else begin
      load_start_q  <= 1'b0;
      conv_start_q  <= 1'b0;
      store_start_q <= 1'b0;
      instr_done_q  <= 1'b0;
      // A new error in the same cycle as err_clr survives the clear.
      err_q         <= (bus.err_clr ? '0 : err_q) | err_set;
      unique case (state_q)
        StIdle: begin
          if (bus.instr_en) begin
            opcode_q <= bus.instr[OPC_LSB +: OPC_W];
            addr_q   <= bus.instr[ADDR_LSB +: ADDR_W];
            len_q    <= bus.instr[LEN_LSB +: LEN_W];
            cfg_q    <= bus.instr[CFG_LSB +: CFG_W];
            busy_q   <= 1'b1;
            state_q  <= StDecode;
          end
        end
        StDecode: begin
          if (op_is_unit(opcode_q)) begin
            load_start_q  <= (opcode_q == OP_LOAD);
            conv_start_q  <= (opcode_q == OP_CONV);
            store_start_q <= (opcode_q == OP_STORE);
            state_q       <= StIssue;
          end else begin
            instr_done_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (sel_done || cnt_expired) begin
            instr_done_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.load_start  = load_start_q;
  assign bus.conv_start  = conv_start_q;
  assign bus.store_start = store_start_q;
  assign bus.param_addr  = addr_q;
  assign bus.param_len   = len_q;
  assign bus.param_cfg   = cfg_q;
  assign bus.instr_done  = instr_done_q;
  assign bus.busy        = busy_q;
  assign bus.err_code    = err_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Randomised bench for instr_dispatch: the driver predicts each instruction's start/done
// timing and error state into queues, and a negedge monitor matches the DUT against them.
module tb_instr_dispatch;

  localparam int TO = 8;

  typedef struct {
    int cyc;
    int unit;
  } start_rec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  err;
    logic [19:0] addr;
    logic [15:0] len;
    logic [23:0] cfg;
  } done_rec_t;

  typedef struct {
    int         cyc;
    logic [1:0] err;
  } err_rec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_dispatch_if dif ();

  instr_dispatch #(
    .TIMEOUT_CYCLES (TO),
    .TO_W           (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  start_rec_t start_q[$];
  done_rec_t  done_q[$];
  err_rec_t   errchk_q[$];
  int         zero_q[$];

  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  bit         fin = 1'b0;
  logic [1:0] err_m = 2'b00;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] mon_st;
  start_rec_t mon_sr;
  done_rec_t  mon_dr;
  err_rec_t   mon_er;

  always @(negedge clk) begin
    mon_st = {dif.store_start, dif.conv_start, dif.load_start};
    chk("start_done_overlap", 64'(|mon_st && dif.instr_done), 64'd0);

    if (|mon_st) begin
      if (start_q.size() == 0) begin
        chk("start_unexpected", 64'(mon_st), 64'd0);
      end else begin
        mon_sr = start_q.pop_front();
        chk("start_cycle", 64'(cyc), 64'(mon_sr.cyc));
        chk("start_unit", 64'(mon_st), 64'(1 << (mon_sr.unit - 1)));
      end
    end else if (start_q.size() != 0 && start_q[0].cyc < cyc) begin
      mon_sr = start_q.pop_front();
      chk("start_missing", 64'(mon_st), 64'(1 << (mon_sr.unit - 1)));
    end

    if (dif.instr_done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 64'(dif.instr_done), 64'd0);
      end else begin
        mon_dr = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_dr.cyc));
        chk("done_err_code", 64'(dif.err_code), 64'(mon_dr.err));
        chk("done_params", {4'h0, dif.param_addr, dif.param_len, dif.param_cfg},
            {4'h0, mon_dr.addr, mon_dr.len, mon_dr.cfg});
      end
    end else if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
      mon_dr = done_q.pop_front();
      chk("done_missing", 64'(dif.instr_done), 64'd1);
    end

    if (errchk_q.size() != 0 && errchk_q[0].cyc == cyc) begin
      mon_er = errchk_q.pop_front();
      chk("err_code", 64'(dif.err_code), 64'(mon_er.err));
    end

    if (zero_q.size() != 0 && zero_q[0] == cyc) begin
      void'(zero_q.pop_front());
      chk("outputs_after_reset",
          {dif.param_addr, dif.param_len, dif.param_cfg, dif.load_start, dif.conv_start,
           dif.store_start, dif.instr_done, dif.busy, dif.err_code},
          64'd0);
    end

    if (fin) begin
      chk("queues_drained",
          64'(start_q.size() + done_q.size() + errchk_q.size() + zero_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end

  // ---------------- driver / reference model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_dones(int op, bit sel, bit noisy);
    dif.load_done  = (op == 1) ? sel : (noisy ? 1'($urandom) : 1'b0);
    dif.conv_done  = (op == 2) ? sel : (noisy ? 1'($urandom) : 1'b0);
    dif.store_done = (op == 3) ? sel : (noisy ? 1'($urandom) : 1'b0);
  endtask

  // k: WAIT cycle (1..TO after the start) on which the unit answers; anything else never answers.
  task automatic issue(logic [63:0] w, int k, bit glitch, bit busy_en, bit noisy);
    int         t0, s, dc, b;
    int         op;
    bit         answers;
    start_rec_t sr;
    done_rec_t  dr;
    op = int'(w[63:60]);
    t0 = cyc;
    dif.instr    = w;
    dif.instr_en = 1'b1;
    tick();
    dif.instr_en = 1'b0;
    dif.instr    = {$urandom, $urandom};
    dr.addr = w[59:40];
    dr.len  = w[39:24];
    dr.cfg  = w[23:0];
    if (op == 0 || op > 3) begin
      dc = t0 + 2;
      if (op > 3) err_m[0] = 1'b1;
      if (busy_en) err_m[1] = 1'b1;
      dr.cyc = dc;
      dr.err = err_m;
      done_q.push_back(dr);
      dif.instr_en = busy_en;
      tick();
      dif.instr_en = 1'b0;
      tick();
    end else begin
      s       = t0 + 2;
      answers = (k >= 1 && k <= TO);
      sr.cyc  = s;
      sr.unit = op;
      start_q.push_back(sr);
      dc = answers ? s + k + 1 : s + TO + 1;
      if (!answers) err_m[0] = 1'b1;
      b = int'($urandom_range(dc - 1, t0 + 1));
      if (busy_en) err_m[1] = 1'b1;
      dr.cyc = dc;
      dr.err = err_m;
      done_q.push_back(dr);
      while (cyc <= dc) begin
        drive_dones(op, (cyc == s && glitch) || (answers && cyc == s + k), noisy);
        dif.instr_en = busy_en && (cyc == b);
        if (dif.instr_en) dif.instr = {$urandom, $urandom};
        tick();
      end
      dif.instr_en = 1'b0;
      drive_dones(0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle_and_check(bit clr);
    err_rec_t er;
    if (clr) begin
      dif.err_clr = 1'b1;
      tick();
      dif.err_clr = 1'b0;
      err_m = 2'b00;
    end
    er.cyc = cyc;
    er.err = err_m;
    errchk_q.push_back(er);
    tick();
  endtask

  task automatic reset_mid_wait();
    int         t0, r;
    start_rec_t sr;
    t0 = cyc;
    dif.instr    = {4'h1, 20'($urandom), 16'($urandom), 24'($urandom)};
    dif.instr_en = 1'b1;
    tick();
    dif.instr_en = 1'b0;
    sr.cyc  = t0 + 2;
    sr.unit = 1;
    start_q.push_back(sr);
    r = t0 + 2 + int'($urandom_range(TO, 1));
    while (cyc < r) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    err_m = 2'b00;
    zero_q.push_back(cyc);
  endtask

  function automatic logic [63:0] rand_word(logic [3:0] op);
    return {op, 20'($urandom), 16'($urandom), 24'($urandom)};
  endfunction

  initial begin
    logic [3:0] op;
    int         r, k;
    rst          = 1'b1;
    dif.instr_en = 1'b0;
    dif.instr    = '0;
    dif.err_clr  = 1'b0;
    drive_dones(0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    zero_q.push_back(cyc);
    tick();

    issue({4'h1, 20'h00010, 16'h0040, 24'h000005}, 4, 1'b0, 1'b0, 1'b0);
    idle_and_check(1'b0);
    issue(rand_word(4'h2), 8, 1'b1, 1'b0, 1'b0);
    idle_and_check(1'b0);
    issue(rand_word(4'h0), 0, 1'b0, 1'b0, 1'b0);
    issue(rand_word(4'hA), 0, 1'b0, 1'b0, 1'b0);
    idle_and_check(1'b0);
    idle_and_check(1'b1);
    issue(rand_word(4'h3), 0, 1'b0, 1'b0, 1'b1);
    idle_and_check(1'b1);
    issue(rand_word(4'h1), 5, 1'b0, 1'b1, 1'b0);
    idle_and_check(1'b1);
    reset_mid_wait();
    issue(rand_word(4'h1), 3, 1'b0, 1'b0, 1'b0);
    idle_and_check(1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9, 0) == 0) begin
        reset_mid_wait();
      end else begin
        r  = int'($urandom_range(7, 0));
        op = (r < 6) ? 4'(r % 4) : 4'($urandom_range(15, 4));
        k  = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(TO, 1));
        issue(rand_word(op), k, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      idle_and_check($urandom_range(2, 0) == 0);
    end

    repeat (3) tick();
    fin = 1'b1;
    repeat (4) tick();
    $display("FAIL monitor did not finish the run");
    $fatal(1);
  end

endmodule
